// File: rtl/uio_arb_pkg.sv
// uio_arb_pkg: shared state encoding and pad-enable constants for the uio bus arbiter
package uio_arb_pkg;
  typedef enum logic [1:0] {IDLE, TURN, XFER} state_e;
  localparam logic [7:0] OE_ALL  = 8'hFF;
  localparam logic [7:0] OE_NONE = 8'h00;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at or after ptr
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  // scan from the farthest slot back to ptr so the closest request wins
  always_comb begin
    valid = |req;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin sequencer sharing the uio pad bus among NREQ clients
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MAX_BURST = 8,
  parameter int W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] dir,
  input  logic [NREQ-1:0] last,
  input  logic [NREQ*8-1:0] wdata,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      rdata,
  output logic            rvalid,
  output logic [W-1:0]    rid,
  output logic            busy,
  input  logic [7:0]      uio_in,
  output logic [7:0]      uio_out,
  output logic [7:0]      uio_oe
);
  state_e       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d, owner_q, owner_d, rid_q, rid_d, pick_idx;
  logic         own_dir_q, own_dir_d, last_dir_q, last_dir_d, rvalid_q, rvalid_d, pick_valid;
  logic [7:0]   beat_cnt_q, beat_cnt_d, rdata_q, rdata_d;
  logic         beat, done;

  rr_pick #(.N(NREQ), .W(W)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign beat = state_q == XFER && req[owner_q];
  assign done = !req[owner_q] || last[owner_q] || beat_cnt_q == 8'(MAX_BURST - 1);

  // state register and all datapath flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      own_dir_q  <= 1'b0;
      last_dir_q <= 1'b0;
      beat_cnt_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      own_dir_q  <= own_dir_d;
      last_dir_q <= last_dir_d;
      beat_cnt_q <= beat_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
    end
  end

  // next state: arbitrate in IDLE, turn the bus around, count beats and release
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    own_dir_d  = own_dir_q;
    last_dir_d = state_q == TURN ? own_dir_q : last_dir_q;
    beat_cnt_d = beat_cnt_q;
    rdata_d    = beat && !own_dir_q ? uio_in : rdata_q;
    rid_d      = beat && !own_dir_q ? owner_q : rid_q;
    rvalid_d   = beat && !own_dir_q;
    if (!ena) begin
      state_d = IDLE;
    end else if (state_q == IDLE && pick_valid) begin
      owner_d    = pick_idx;
      own_dir_d  = dir[pick_idx];
      beat_cnt_d = '0;
      state_d    = dir[pick_idx] != last_dir_q ? TURN : XFER;
    end else if (state_q == TURN) begin
      state_d = XFER;
    end else if (state_q == XFER && done) begin
      state_d = IDLE;
      ptr_d   = owner_q == W'(NREQ - 1) ? '0 : owner_q + 1'b1;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
  end

  // outputs decoded from flopped state only; the bus is driven for whole write grants
  always_comb begin
    busy    = state_q != IDLE;
    gnt     = state_q == XFER ? NREQ'(1) << owner_q : '0;
    uio_oe  = state_q == XFER && own_dir_q ? OE_ALL : OE_NONE;
    uio_out = state_q == XFER && own_dir_q ? wdata[int'(owner_q) * 8 +: 8] : 8'h00;
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rid    = rid_q;
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: directed scenarios plus randomized run against a behavioural model
module tb_uio_bus_arbiter;
  localparam int N = 4;
  localparam int MB = 8;
  logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [3:0]  req = '0, dir = '0, last = '0, gnt;
  logic [31:0] wdata = '0;
  logic [7:0]  rdata, uio_in = '0, uio_out, uio_oe;
  logic        rvalid, busy;
  logic [1:0]  rid;
  int total = 0, bad = 0;
  int m_owner, m_ptr, m_beats, m_rid;
  bit m_turn, m_dir, m_last_dir, m_rvalid;
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  uio_bus_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .dir(dir), .last(last),
    .wdata(wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .rid(rid),
    .busy(busy), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_beats = 0; m_rid = 0;
    m_turn = 0; m_dir = 0; m_last_dir = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic model_step();
    bit b;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_rvalid = 0;
    if (m_owner < 0) begin
      if (ena && req != 0) begin
        for (int k = 0; k < N; k++) if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_dir = dir[m_owner];
        m_beats = 0;
        m_turn = m_dir != m_last_dir;
      end
    end else if (m_turn) begin
      m_last_dir = m_dir;
      m_turn = 0;
      if (!ena) m_owner = -1;
    end else begin
      b = req[m_owner];
      if (b && !m_dir) begin
        m_rvalid = 1; m_rdata = uio_in; m_rid = m_owner;
      end
      if (!ena) m_owner = -1;
      else if (!b || last[m_owner] || m_beats == MB - 1) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else m_beats++;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; ena = 1; req = 4'hF; dir = 4'hF;
    tick(); tick();
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin bad++; $display("FAIL reset_pad got oe=%h out=%h exp 00/00", uio_oe, uio_out); end
    total++; if (rdata !== 8'h00 || rvalid !== 1'b0 || rid !== 2'd0) begin bad++; $display("FAIL reset_read got rdata=%h rvalid=%b rid=%0d exp 0", rdata, rvalid, rid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1; req = '0; dir = '0;
  endtask

  task automatic test_write();
    req = 4'b0100; dir = 4'b0100; wdata = 32'h00A5_0000; last = '0;
    tick();
    total++; if (gnt !== 4'b0 || uio_oe !== 8'h00 || busy !== 1'b1) begin bad++; $display("FAIL write_turn got gnt=%b oe=%h busy=%b exp 0000/00/1", gnt, uio_oe, busy); end
    for (int b = 0; b < 3; b++) begin
      tick();
      total++; if (gnt !== 4'b0100 || uio_oe !== 8'hFF || uio_out !== 8'hA5) begin bad++; $display("FAIL write_beat%0d got gnt=%b oe=%h out=%h exp 0100/ff/a5", b, gnt, uio_oe, uio_out); end
      if (b == 2) last = 4'b0100;
    end
    tick();
    total++; if (gnt !== 4'b0 || uio_oe !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL write_end got gnt=%b oe=%h busy=%b exp 0000/00/0", gnt, uio_oe, busy); end
    req = '0; last = '0; dir = '0;
  endtask

  task automatic test_read();
    req = 4'b0010; dir = '0; last = 4'b0010; uio_in = 8'h3C;
    tick();
    total++; if (gnt !== 4'b0 || busy !== 1'b1) begin bad++; $display("FAIL read_turn got gnt=%b busy=%b exp 0000/1", gnt, busy); end
    tick();
    total++; if (gnt !== 4'b0010 || rvalid !== 1'b0 || uio_oe !== 8'h00) begin bad++; $display("FAIL read_beat got gnt=%b rvalid=%b oe=%h exp 0010/0/00", gnt, rvalid, uio_oe); end
    tick();
    total++; if (rvalid !== 1'b1 || rdata !== 8'h3C || rid !== 2'd1 || busy !== 1'b0) begin bad++; $display("FAIL read_data got rvalid=%b rdata=%h rid=%0d busy=%b exp 1/3c/1/0", rvalid, rdata, rid, busy); end
    uio_in = 8'h5A;
    tick();
    total++; if (gnt !== 4'b0010 || rvalid !== 1'b0) begin bad++; $display("FAIL read_noturn got gnt=%b rvalid=%b exp 0010/0", gnt, rvalid); end
    tick();
    total++; if (rvalid !== 1'b1 || rdata !== 8'h5A || rid !== 2'd1) begin bad++; $display("FAIL read_data2 got rvalid=%b rdata=%h rid=%0d exp 1/5a/1", rvalid, rdata, rid); end
    req = '0; last = '0;
    tick();
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL read_pulse got rvalid=%b exp 0", rvalid); end
  endtask

  task automatic test_round_robin();
    rst_n = 0; req = '0;
    tick();
    rst_n = 1; req = 4'hF; last = 4'hF; dir = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (gnt !== 4'(1 << (k % N))) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, gnt, 4'(1 << (k % N))); end
      tick();
      total++; if (gnt !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL rr_idle%0d got gnt=%b busy=%b exp 0000/0", k, gnt, busy); end
    end
    req = '0; last = '0;
    tick();
  endtask

  task automatic test_forced_release();
    rst_n = 0; req = '0;
    tick();
    rst_n = 1; req = 4'b1001; dir = '0; last = 4'b1000;
    for (int b = 0; b < MB; b++) begin
      tick();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL force_beat%0d got=%b exp=0001", b, gnt); end
    end
    tick();
    total++; if (gnt !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL force_release got gnt=%b busy=%b exp 0000/0", gnt, busy); end
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL force_next got=%b exp=1000", gnt); end
    tick(); tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL force_again got=%b exp=0001", gnt); end
    req = '0; last = '0;
    tick(); tick();
  endtask

  task automatic test_abort();
    rst_n = 0; req = '0;
    tick();
    rst_n = 1; req = 4'b0001; dir = 4'b0001; wdata = 32'h0000_0077; last = '0;
    tick(); tick();
    total++; if (uio_oe !== 8'hFF || uio_out !== 8'h77 || gnt !== 4'b0001) begin bad++; $display("FAIL abort_pre got oe=%h out=%h gnt=%b exp ff/77/0001", uio_oe, uio_out, gnt); end
    ena = 0;
    tick();
    total++; if (gnt !== 4'b0 || uio_oe !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL abort_ena got gnt=%b oe=%h busy=%b exp 0000/00/0", gnt, uio_oe, busy); end
    ena = 1; req = '0; dir = '0;
    tick();
    req = 4'b0010; uio_in = 8'hE1;
    tick(); tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL abort_rd_gnt got=%b exp=0010", gnt); end
    rst_n = 0;
    tick();
    total++; if (rvalid !== 1'b0 || busy !== 1'b0 || rdata !== 8'h00) begin bad++; $display("FAIL abort_rst got rvalid=%b busy=%b rdata=%h exp 0/0/00", rvalid, busy, rdata); end
    rst_n = 1; req = '0;
  endtask

  task automatic test_random();
    logic [3:0] eg;
    logic [7:0] eo;
    bit act;
    rst_n = 0; ena = 1; req = '0;
    tick();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n = $urandom_range(0, 199) != 0;
      ena = $urandom_range(0, 99) < 95;
      for (int i = 0; i < N; i++) begin
        req[i] = $urandom_range(0, 3) != 0;
        last[i] = $urandom_range(0, 3) == 0;
      end
      dir = 4'($urandom); wdata = $urandom; uio_in = 8'($urandom);
      #1;
      act = m_owner >= 0 && !m_turn;
      eg = act ? 4'(1 << m_owner) : 4'b0;
      eo = act && m_dir ? wdata[m_owner * 8 +: 8] : 8'h00;
      total++; if (gnt !== eg) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      total++; if (uio_oe !== (act && m_dir ? 8'hFF : 8'h00) || uio_out !== eo) begin bad++; $display("FAIL rnd_pad c=%0d got oe=%h out=%h exp out=%h", c, uio_oe, uio_out, eo); end
      total++; if (busy !== (m_owner >= 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_owner >= 0); end
      total++; if (rvalid !== m_rvalid || rdata !== m_rdata || rid !== 2'(m_rid)) begin bad++; $display("FAIL rnd_read c=%0d got %b/%h/%0d exp %b/%h/%0d", c, rvalid, rdata, rid, m_rvalid, m_rdata, m_rid); end
      model_step();
      @(posedge clk);
      #1;
    end
    rst_n = 1; ena = 1; req = '0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_forced_release();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
